frame_mapper_gen: RTL and testbench
===================================

# frame_mapper_gen

Parametrised second-generation sender mapper: builds fixed-size frames of ROWS×COLS bytes from an AXIS-style byte stream. The frame carries a two-byte FAS, an ARQ sequence-number byte and a trailing CRC-8. It sits between the client RX FIFO and the line FIFO / serial transmitter. Unlike the first-generation mapper, frame geometry, FAS pattern and CRC polynomial are parameters, and the block has an optional idle-fill mode and an internal frame sequence counter.

## Interface
- ROWS, 4, rows per frame (≥1)
- COLS, 1088, columns (bytes) per row (≥5)
- FAS0, 8'hF6, first FAS byte
- FAS1, 8'h28, second FAS byte
- CRC_POLY, 8'h07, CRC-8 polynomial (MSB-first, init 0x00, no reflection, no final XOR)
- IDLE_BYTE, 8'h00, fill byte used when fill mode is on and payload is absent
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_pyld_data  in  8  client payload byte
- i_pyld_data_valid  in  1  AXIS valid
- o_pyld_data_req  out  1  AXIS ready
- o_frame_data  out  8  frame byte
- o_frame_data_valid  out  1  frame byte strobe
- o_frame_data_fas  out  1  high with the FAS0 byte
- i_line_ready  in  1  line FIFO and retransmission-record FIFO both ready
- i_retrans_req  in  1  retransmission in progress; freezes mapping
- i_arq_en  in  1  insert sequence number in the overhead byte
- i_fill_en  in  1  idle-fill mode
- o_crc_val  out  8  CRC of last completed frame
- o_frame_seq  out  8  sequence number of the current frame
- o_row_cnt  out  max(1,$clog2(ROWS))  row of next byte
- o_col_cnt  out  $clog2(COLS)  column of next byte

## Operation
- Frame layout, row-major:
  - (0,0) = FAS0
  - (0,1) = FAS1
  - (0,2) = overhead: o_frame_seq if i_arq_en, else 0x00
  - (ROWS-1,COLS-1) = CRC
  - all other positions are payload; ROWS*COLS-4 payload bytes per frame.
- Base enable: en = i_line_ready & !i_retrans_req.
- Step (emit one byte, advance position) occurs when en and one of:
  - position is FAS, overhead or CRC
  - position is payload and i_pyld_data_valid
  - position is payload, !i_pyld_data_valid and i_fill_en (emit IDLE_BYTE).
- o_pyld_data_req = en & (position is payload). It is combinational and never depends on i_pyld_data_valid. A transfer occurs when valid & req.
- Payload present and fill on in the same cycle: real payload wins.
- Payload absent with fill off: no step. Position holds and req stays high.
- CRC accumulator:
  - updated on every emitted payload or fill byte
  - excludes FAS, overhead and CRC bytes
  - at the CRC step the current accumulator is emitted and latched into o_crc_val, and the accumulator clears to 0x00.
- Sequence counter:
  - 8-bit, increments on the CRC step, wraps 0xFF→0x00
  - i_arq_en is sampled at the (0,2) step only.
- Position counter:
  - col increments per step
  - at COLS-1, col goes to 0 and row increments
  - after (ROWS-1,COLS-1), position wraps to (0,0).
- i_retrans_req overrides i_line_ready: counters, CRC and sequence all hold.
- Reset (async, any time, including mid-frame):
  - row, col, CRC, sequence, o_frame_data, o_frame_data_valid, o_frame_data_fas and o_crc_val all go to 0
  - the partial frame is abandoned; the next emitted byte is FAS0.
- o_pyld_data_req during reset is 0, because en is gated by reset.

## Timing
- Latency: one cycle. The step at edge N produces o_frame_data / o_frame_data_valid (and o_frame_data_fas for FAS0) registered, visible after edge N.
- o_frame_data_valid is high for exactly one cycle per step. Full throughput is one byte per clock.
- o_frame_data holds its last value when valid is low.
- o_crc_val updates in the same cycle the CRC byte appears on o_frame_data.
- o_frame_seq increments in that same cycle.
- o_row_cnt / o_col_cnt reflect the position of the next byte. They update on the step edge.

## Test plan
- **Basic frame.** ROWS=1, COLS=13, i_arq_en=1, line ready, feed 0x31..0x39 ("123456789") back-to-back.
  - Output over 13 consecutive cycles: F6,28,00,31..39,F4.
  - o_frame_data_fas only on F6; o_crc_val=F4; o_frame_seq=1.
  - Second frame's overhead byte = 01.
- **ARQ disabled.** Same setup, i_arq_en=0 after 5 frames.
  - Overhead byte = 00 while o_frame_seq=5.
- **Backpressure.** i_line_ready low for 3 cycles during payload, then i_retrans_req high for 4 cycles with ready high.
  - req and valid are low in both windows; counters hold.
  - Output byte stream is identical to scenario 1, with no loss or duplication.
- **Fill mode vs stall.** With i_fill_en=1 and valid never asserted:
  - Output: F6,28,seq, nine 0x00, CRC 0x00.
  - With i_fill_en=0: output stops after the overhead byte; req stays high; the frame resumes when valid rises.
- **Reset mid-frame.** Assert i_rst asynchronously after 5 bytes.
  - All outputs are 0 immediately, before the next clock edge.
  - After release, the first byte is F6, overhead is 00, and the CRC covers only the new payload.
- **Sequence wrap.** Run 257 frames with ROWS=1, COLS=5.
  - Overhead bytes are 0x00..0xFF, then 0x00.
  - o_frame_seq returns to 0x01 after frame 257.

Source files
------------

// File: rtl/frame_mapper_gen_if.sv
// Byte-stream bundle around the frame mapper: client payload in, framed bytes out.
interface frame_mapper_gen_if;
  logic [7:0] pyld_data;
  logic       pyld_data_valid;
  logic       pyld_data_req;
  logic [7:0] frame_data;
  logic       frame_data_valid;
  logic       frame_data_fas;

  // slave: the mapper (consumes payload, produces frame bytes)
  modport slave (
    input  pyld_data, pyld_data_valid,
    output pyld_data_req, frame_data, frame_data_valid, frame_data_fas
  );

  // master: the client/line side driving payload and observing frames
  modport master (
    output pyld_data, pyld_data_valid,
    input  pyld_data_req, frame_data, frame_data_valid, frame_data_fas
  );
endinterface

// File: rtl/frame_mapper_gen.sv
// Parametrised frame mapper: wraps a payload byte stream into ROWS x COLS frames
// carrying FAS0/FAS1, a sequence/overhead byte and a trailing CRC-8.
module frame_mapper_gen #(
  parameter int          ROWS      = 4,
  parameter int          COLS      = 1088,
  parameter logic [7:0]  FAS0      = 8'hF6,
  parameter logic [7:0]  FAS1      = 8'h28,
  parameter logic [7:0]  CRC_POLY  = 8'h07,
  parameter logic [7:0]  IDLE_BYTE = 8'h00,
  localparam int         RW        = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int         CW        = $clog2(COLS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  frame_mapper_gen_if.slave    bus,
  input  logic                 i_line_ready,
  input  logic                 i_retrans_req,
  input  logic                 i_arq_en,
  input  logic                 i_fill_en,
  output logic [7:0]           o_crc_val,
  output logic [7:0]           o_frame_seq,
  output logic [RW-1:0]        o_row_cnt,
  output logic [CW-1:0]        o_col_cnt
);

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [7:0]    r_crc;
  logic [7:0]    r_crc_val;
  logic [7:0]    r_seq;
  logic [7:0]    r_frame_data;
  logic          r_frame_valid;
  logic          r_frame_fas;

  logic       w_en, w_top, w_fas0, w_fas1, w_ovh, w_crc_pos, w_pyld, w_step;
  logic [7:0] w_byte;

  function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int i = 0; i < 8; i++)
      r = r[7] ? ((r << 1) ^ CRC_POLY) : (r << 1);
    return r;
  endfunction

  // Reset gates the enable so the client never sees a request while in reset.
  assign w_en      = i_line_ready & ~i_retrans_req & ~i_rst;
  assign w_top     = (r_row == '0);
  assign w_fas0    = w_top & (r_col == CW'(0));
  assign w_fas1    = w_top & (r_col == CW'(1));
  assign w_ovh     = w_top & (r_col == CW'(2));
  assign w_crc_pos = (r_row == RW'(ROWS-1)) & (r_col == CW'(COLS-1));
  assign w_pyld    = ~(w_fas0 | w_fas1 | w_ovh | w_crc_pos);
  assign w_step    = w_en & (~w_pyld | bus.pyld_data_valid | i_fill_en);

  assign bus.pyld_data_req = w_en & w_pyld;

  always_comb begin
    w_byte = IDLE_BYTE;
    if (w_fas0)                    w_byte = FAS0;
    else if (w_fas1)               w_byte = FAS1;
    else if (w_ovh)                w_byte = i_arq_en ? r_seq : 8'h00;
    else if (w_crc_pos)            w_byte = r_crc;
    else if (bus.pyld_data_valid)  w_byte = bus.pyld_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_row         <= '0;
      r_col         <= '0;
      r_crc         <= '0;
      r_crc_val     <= '0;
      r_seq         <= '0;
      r_frame_data  <= '0;
      r_frame_valid <= 1'b0;
      r_frame_fas   <= 1'b0;
    end else begin
      r_frame_valid <= w_step;
      r_frame_fas   <= w_step & w_fas0;
      if (w_step) begin
        r_frame_data <= w_byte;
        if (w_crc_pos) begin
          r_crc_val <= r_crc;
          r_crc     <= '0;
          r_seq     <= r_seq + 8'd1;
        end else if (w_pyld) begin
          r_crc <= crc8_upd(r_crc, w_byte);
        end
        if (r_col == CW'(COLS-1)) begin
          r_col <= '0;
          r_row <= (r_row == RW'(ROWS-1)) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  assign bus.frame_data       = r_frame_data;
  assign bus.frame_data_valid = r_frame_valid;
  assign bus.frame_data_fas   = r_frame_fas;
  assign o_crc_val            = r_crc_val;
  assign o_frame_seq          = r_seq;
  assign o_row_cnt            = r_row;
  assign o_col_cnt            = r_col;

endmodule

// File: tb/tb_frame_mapper_gen.sv
// Bench for frame_mapper_gen: directed 1x13 frames on one instance, randomized
// 3x6 traffic against a frame-level reference model on a second instance.
module tb_frame_mapper_gen;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // ---------------- instance A: ROWS=1, COLS=13, default patterns
  frame_mapper_gen_if a_if ();
  logic       a_rdy, a_rt, a_arq, a_fill;
  logic [7:0] a_crc, a_seq;
  logic [0:0] a_row;
  logic [3:0] a_col;

  frame_mapper_gen #(.ROWS(1), .COLS(13)) u_a (
    .i_clk(clk), .i_rst(rst), .bus(a_if),
    .i_line_ready(a_rdy), .i_retrans_req(a_rt), .i_arq_en(a_arq), .i_fill_en(a_fill),
    .o_crc_val(a_crc), .o_frame_seq(a_seq), .o_row_cnt(a_row), .o_col_cnt(a_col)
  );

  // ---------------- instance B: ROWS=3, COLS=6, non-default patterns
  localparam int         BR = 3, BC = 6, BN = BR*BC;
  localparam logic [7:0] B_FAS0 = 8'hA5, B_FAS1 = 8'h3C, B_POLY = 8'h1D, B_IDLE = 8'h55;
  frame_mapper_gen_if b_if ();
  logic       b_rdy, b_rt, b_arq, b_fill;
  logic [7:0] b_crc, b_seq;
  logic [1:0] b_row;
  logic [2:0] b_col;

  frame_mapper_gen #(.ROWS(BR), .COLS(BC), .FAS0(B_FAS0), .FAS1(B_FAS1),
                     .CRC_POLY(B_POLY), .IDLE_BYTE(B_IDLE)) u_b (
    .i_clk(clk), .i_rst(rst), .bus(b_if),
    .i_line_ready(b_rdy), .i_retrans_req(b_rt), .i_arq_en(b_arq), .i_fill_en(b_fill),
    .o_crc_val(b_crc), .o_frame_seq(b_seq), .o_row_cnt(b_row), .o_col_cnt(b_col)
  );

  typedef struct {
    logic v; logic [7:0] d; logic rdy, rt, fill, arq;
    logic e_req, e_vld; logic [7:0] e_dat; logic e_fas; int e_col;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic rdy,
                              input logic rt, input logic fill, input logic arq,
                              input logic e_req, input logic e_vld, input logic [7:0] e_dat,
                              input logic e_fas, input int e_col);
    vec_t t;
    t.v = v; t.d = d; t.rdy = rdy; t.rt = rt; t.fill = fill; t.arq = arq;
    t.e_req = e_req; t.e_vld = e_vld; t.e_dat = e_dat; t.e_fas = e_fas; t.e_col = e_col;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle on A, check the combinational request, then the registered outputs.
  task automatic cyc(input vec_t t);
    a_if.pyld_data_valid = t.v; a_if.pyld_data = t.d;
    a_rdy = t.rdy; a_rt = t.rt; a_fill = t.fill; a_arq = t.arq;
    #1 chk("a_req", a_if.pyld_data_req, t.e_req);
    @(posedge clk); #1;
    chk("a_vld", a_if.frame_data_valid, t.e_vld);
    chk("a_dat", a_if.frame_data, t.e_dat);
    chk("a_fas", a_if.frame_data_fas, t.e_fas);
    chk("a_col", a_col, t.e_col);
  endtask

  // One 1x13 frame on A: payload "123456789" or all fill, optional stall before payload.
  task automatic run_frame(input logic arq, input logic fillm, input logic [7:0] ovh,
                           input int stall, input int nbytes, input logic [7:0] exp_seq);
    logic [7:0] eb, pd;
    for (int k = 0; k < nbytes; k++) begin
      if (k == 3)
        for (int s = 0; s < stall; s++) cyc(mk(0, 8'h00, 1, 0, 0, arq, 1, 0, ovh, 0, 3));
      pd = 8'h30 + 8'(k - 2);
      case (k)
        0:       eb = 8'hF6;
        1:       eb = 8'h28;
        2:       eb = ovh;
        12:      eb = fillm ? 8'h00 : 8'hF4;
        default: eb = fillm ? 8'h00 : pd;
      endcase
      cyc(mk(!fillm, pd, 1, 0, fillm, arq, (k >= 3 && k <= 11), 1, eb, (k == 0), (k + 1) % 13));
    end
    if (nbytes == 13) begin
      chk("a_crc_val", a_crc, fillm ? 8'h00 : 8'hF4);
      chk("a_seq", a_seq, exp_seq);
    end
  endtask

  // CRC as the remainder of the zero-augmented message divided by x^8+POLY.
  function automatic logic [7:0] ref_crc(input logic [7:0] poly, input logic [7:0] m[$]);
    logic [7:0] r;
    logic msb;
    r = '0;
    for (int i = 0; i < m.size() + 1; i++)
      for (int j = 7; j >= 0; j--) begin
        msb = r[7];
        r = {r[6:0], (i < m.size()) ? m[i][j] : 1'b0};
        if (msb) r = r ^ poly;
      end
    return r;
  endfunction

  vec_t       tbl[$];
  logic [7:0] m_q[$];
  int         m_k, m_frames;
  logic [7:0] m_seq, m_crc, m_last, eb;
  logic       v, rdy, rt, fill, arq, en, pay, step, was_fas;
  logic [7:0] d;

  initial begin
    rst = 1'b1;
    a_if.pyld_data = '0; a_if.pyld_data_valid = 1'b0;
    b_if.pyld_data = '0; b_if.pyld_data_valid = 1'b0;
    a_rdy = 1'b1; a_rt = 1'b0; a_arq = 1'b1; a_fill = 1'b0;
    b_rdy = 1'b0; b_rt = 1'b0; b_arq = 1'b0; b_fill = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_vld", a_if.frame_data_valid, 0);
    chk("rst_dat", a_if.frame_data, 0);
    chk("rst_req", a_if.pyld_data_req, 0);
    chk("rst_crc", a_crc, 0);
    rst = 1'b0;

    // Frame 1: back-to-back "123456789", with line-not-ready and retransmit stalls.
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 1, 8'hF6, 1, 1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 1, 8'h28, 0, 2));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 1, 8'h00, 0, 3));
    tbl.push_back(mk(1, 8'h31, 1, 0, 0, 1, 1, 1, 8'h31, 0, 4));
    tbl.push_back(mk(1, 8'h32, 1, 0, 0, 1, 1, 1, 8'h32, 0, 5));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 8'h33, 0, 0, 0, 1, 0, 0, 8'h32, 0, 5));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 8'h33, 1, 1, 0, 1, 0, 0, 8'h32, 0, 5));
    for (int i = 3; i <= 9; i++)
      tbl.push_back(mk(1, 8'h30 + 8'(i), 1, 0, 0, 1, 1, 1, 8'h30 + 8'(i), 0, i + 3));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 1, 8'hF4, 0, 0));
    foreach (tbl[i]) cyc(tbl[i]);
    chk("f1_crc_val", a_crc, 8'hF4);
    chk("f1_seq", a_seq, 8'h01);

    run_frame(1, 0, 8'h01, 3, 13, 8'h02);   // stall with fill off, then resume
    run_frame(1, 1, 8'h02, 0, 13, 8'h03);   // pure idle-fill frame
    run_frame(0, 0, 8'h00, 0, 13, 8'h04);   // ARQ off: overhead 00 while seq=3
    run_frame(1, 0, 8'h04, 0, 5, 8'h00);    // partial frame, then async reset

    a_if.pyld_data_valid = 1'b1; a_if.pyld_data = 8'h33;
    #1 chk("pre_rst_req", a_if.pyld_data_req, 1);
    rst = 1'b1;
    #1;
    chk("arst_vld", a_if.frame_data_valid, 0);
    chk("arst_dat", a_if.frame_data, 0);
    chk("arst_fas", a_if.frame_data_fas, 0);
    chk("arst_req", a_if.pyld_data_req, 0);
    chk("arst_crc", a_crc, 0);
    chk("arst_seq", a_seq, 0);
    chk("arst_col", a_col, 0);
    #2 rst = 1'b0;
    run_frame(1, 0, 8'h00, 0, 13, 8'h01);

    // Randomized traffic on B against the frame-level model.
    a_rdy = 1'b0;
    rst = 1'b1; #3 rst = 1'b0;
    m_k = 0; m_seq = '0; m_crc = '0; m_last = '0; m_frames = 0; m_q.delete();
    @(posedge clk); #1;
    for (int c = 0; c < 9000; c++) begin
      v = ($urandom_range(0, 3) != 0); d = 8'($urandom);
      rdy = ($urandom_range(0, 9) != 0); rt = ($urandom_range(0, 19) == 0);
      fill = ($urandom_range(0, 3) == 0); arq = 1'($urandom_range(0, 1));
      b_if.pyld_data_valid = v; b_if.pyld_data = d;
      b_rdy = rdy; b_rt = rt; b_fill = fill; b_arq = arq;
      #1;
      en = rdy && !rt;
      pay = (m_k >= 3) && (m_k < BN - 1);
      chk("b_req", b_if.pyld_data_req, en && pay);
      step = en && (!pay || v || fill);
      was_fas = step && (m_k == 0);
      if (step) begin
        if (m_k == 0)           eb = B_FAS0;
        else if (m_k == 1)      eb = B_FAS1;
        else if (m_k == 2)      eb = arq ? m_seq : 8'h00;
        else if (m_k == BN - 1) eb = ref_crc(B_POLY, m_q);
        else                    eb = v ? d : B_IDLE;
        if (pay) m_q.push_back(eb);
        if (m_k == BN - 1) begin
          m_crc = eb; m_seq = m_seq + 8'd1; m_q.delete(); m_frames++;
        end
        m_k = (m_k + 1) % BN;
        m_last = eb;
      end
      @(posedge clk); #1;
      chk("b_vld", b_if.frame_data_valid, step);
      chk("b_dat", b_if.frame_data, m_last);
      chk("b_fas", b_if.frame_data_fas, was_fas);
      chk("b_row", b_row, m_k / BC);
      chk("b_col", b_col, m_k % BC);
      chk("b_crc_val", b_crc, m_crc);
      chk("b_seq", b_seq, m_seq);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
